// File: rtl/mem_dump_reader_if.sv
// Command, memory-port and stream signals of mem_dump_reader.
// checksum exists only when DUMP_CHECKSUM_EN is defined.
interface mem_dump_reader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   word_count;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   modport master (
      input  start, base_addr, word_count, mem_rd_data, out_ready,
      output busy, done, mem_rd_en, mem_addr, out_valid, out_addr, out_data
`ifdef DUMP_CHECKSUM_EN
      , output checksum
`endif
   );

   modport slave (
      output start, base_addr, word_count, mem_rd_data, out_ready,
      input  busy, done, mem_rd_en, mem_addr, out_valid, out_addr, out_data
`ifdef DUMP_CHECKSUM_EN
      , input checksum
`endif
   );
endinterface

// File: rtl/mem_dump_reader.sv
// Streams a word range of a synchronous-read memory as {addr,data} through a
// 2-entry credit-controlled FIFO. Optional running checksum: DUMP_CHECKSUM_EN.
module mem_dump_reader #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input logic             clk,
   input logic             reset,
   mem_dump_reader_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W:0]   issued;
   logic [ADDR_W-1:0] rd_addr;
   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [ADDR_W-1:0] fifo_addr [2];
   logic [DATA_W-1:0] fifo_data [2];
   logic [1:0]        fifo_count;
   logic              wr_ptr, rd_ptr;
   logic              rd_en, pop, push, accept;
   logic [2:0]        occupancy;

   assign pop       = bus.out_valid && bus.out_ready;
   assign push      = vld_p1;
   // Slots already claimed once this cycle's pop is accounted for.
   assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            accept    = 1'b1;
            state_nxt = (bus.word_count == '0) ? DONE : RUN;
         end
         RUN: begin
            if (issued == count_r) state_nxt = DRAIN;
            else                   rd_en     = (occupancy < 3'd2);
         end
         DRAIN: if (fifo_count == 2'd0 && !vld_p1) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         count_r    <= '0;
         issued     <= '0;
         rd_addr    <= '0;
         vld_p1     <= 1'b0;
         addr_p1    <= '0;
         fifo_count <= 2'd0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_addr[i] <= '0;
            fifo_data[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         if (accept) begin
            count_r <= bus.word_count;
            issued  <= '0;
            rd_addr <= bus.base_addr;
         end else if (rd_en) begin
            issued  <= issued + 1'b1;
            rd_addr <= rd_addr + 1'b1;
         end
         // p0 -> p1: read issued, data returns next cycle
         vld_p1 <= rd_en;
         if (rd_en) addr_p1 <= rd_addr;
         // p1 -> FIFO: capture returned word with its address
         if (push) begin
            fifo_addr[wr_ptr] <= addr_p1;
            fifo_data[wr_ptr] <= bus.mem_rd_data;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.mem_rd_en = rd_en;
   assign bus.mem_addr  = rd_addr;
   assign bus.out_valid = (fifo_count != 2'd0);
   assign bus.out_addr  = fifo_addr[rd_ptr];
   assign bus.out_data  = fifo_data[rd_ptr];

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_r;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      sum_r <= '0;
      else if (accept) sum_r <= '0;
      else if (pop)    sum_r <= sum_r + bus.out_data;
   end

   assign bus.checksum = sum_r;
`endif
endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized scoreboard bench for mem_dump_reader: a memory model plus an
// address-order reference queue checked by an independent stream monitor.
module tb_mem_dump_reader;
   localparam int AW = 12;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } word_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   mem_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [1 << AW];
   logic [DW-1:0] mem_q;
   always_ff @(posedge clk) if (bus.mem_rd_en) mem_q <= mem[bus.mem_addr];
   assign bus.mem_rd_data = mem_q;

   word_t         q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            ready_mode = 0;
   bit            zero_mode = 1'b0;
   logic [DW-1:0] exp_sum = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // out_ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random
   initial begin
      int ph = 0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            1:       begin bus.out_ready = (ph == 0); ph = (ph + 1) % 3; end
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops expected words on every handshake
   logic          stall_pend = 1'b0;
   logic [AW-1:0] held_a;
   logic [DW-1:0] held_d;
   always @(negedge clk) begin
      if (reset) begin
         if (stall_pend)
            check("stall_hold", {1'b1, bus.out_valid, bus.out_addr, bus.out_data},
                  {1'b1, 1'b1, held_a, held_d});
         stall_pend = bus.out_valid && !bus.out_ready;
         held_a     = bus.out_addr;
         held_d     = bus.out_data;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_word: got addr %0h data %0h, expected none",
                        bus.out_addr, bus.out_data);
            end else begin
               word_t w;
               w = q.pop_front();
               check("word_addr", 64'(bus.out_addr), 64'(w.a));
               check("word_data", 64'(bus.out_data), 64'(w.d));
            end
         end
         if (zero_mode) check("zero_no_traffic", {62'd0, bus.mem_rd_en, bus.out_valid}, 64'd0);
      end else begin
         stall_pend = 1'b0;
      end
   end

   // Called just after a rising edge; returns just after a rising edge.
   task automatic run_dump(input logic [AW-1:0] b, input logic [AW:0] c, input bit poke);
      bit got;
      int k;
      bus.start      = 1'b1;
      bus.base_addr  = b;
      bus.word_count = c;
      exp_sum        = '0;
      for (int i = 0; i < int'(c); i++) begin
         word_t w;
         w.a = AW'(int'(b) + i);
         w.d = mem[w.a];
         q.push_back(w);
         exp_sum += w.d;
      end
      zero_mode = (c == 0);
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.base_addr  = AW'($urandom);
      bus.word_count = (AW+1)'($urandom);
      @(negedge clk);
      check("busy_after_start", 64'(bus.busy), 64'd1);
`ifdef DUMP_CHECKSUM_EN
      check("checksum_cleared", 64'(bus.checksum), 64'd0);
`endif
      got = 1'b0;
      if (c == 0) begin
         check("zero_done", 64'(bus.done), 64'd1);
         got = 1'b1;
      end else begin
         check("first_rd_en", {62'd0, bus.mem_rd_en, bus.done}, 64'd2);
         @(negedge clk);
         check("valid_not_early", 64'(bus.out_valid), 64'd0);
         @(negedge clk);
         check("valid_latency", 64'(bus.out_valid), 64'd1);
         if (poke) begin
            @(posedge clk); #1;
            bus.start      = 1'b1;
            bus.base_addr  = AW'($urandom);
            bus.word_count = (AW+1)'($urandom_range(1, 50));
            @(posedge clk); #1;
            bus.start = 1'b0;
         end
         k = 0;
         while (!got && k < int'(c) * 8 + 40) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            k++;
         end
      end
      check("done_seen", 64'(got), 64'd1);
`ifdef DUMP_CHECKSUM_EN
      check("checksum_final", 64'(bus.checksum), 64'(exp_sum));
`endif
      @(negedge clk);
      check("done_single_pulse", {62'd0, bus.done, bus.busy}, 64'd0);
      check("all_words_seen", 64'(q.size()), 64'd0);
      q.delete();
      zero_mode = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
      mem[12'h800] = 32'd1;
      mem[12'h801] = 32'd1;
      mem[12'h802] = 32'd2;
      mem[12'h803] = 32'd3;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.word_count = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {bus.busy, bus.done, bus.mem_rd_en, bus.out_valid,
                              bus.mem_addr, bus.out_addr, bus.out_data}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      ready_mode = 0; run_dump(12'h800, 13'd4, 1'b0);
      ready_mode = 1; run_dump(12'h800, 13'd4, 1'b0);
      ready_mode = 0; run_dump(12'hFFE, 13'd4, 1'b0);
      run_dump(12'h123, 13'd0, 1'b0);
      ready_mode = 1; run_dump(12'h040, 13'd8, 1'b1);

      // Abort during word 2 of an 8-word dump
      ready_mode = 0;
      bus.start = 1'b1; bus.base_addr = 12'h100; bus.word_count = 13'd8;
      for (int i = 0; i < 8; i++) begin
         word_t w;
         w.a = AW'(12'h100 + i);
         w.d = mem[w.a];
         q.push_back(w);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("abort_outputs", {bus.busy, bus.done, bus.mem_rd_en, bus.out_valid,
                              bus.mem_addr, bus.out_addr, bus.out_data}, 64'd0);
`ifdef DUMP_CHECKSUM_EN
      check("abort_checksum", 64'(bus.checksum), 64'd0);
`endif
      q.delete();
      repeat (2) @(negedge clk);
      check("abort_no_done", 64'(bus.done), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      run_dump(12'h000, 13'd1, 1'b0);

      ready_mode = 2;
      for (int n = 0; n < 8; n++)
         run_dump(AW'($urandom), (AW+1)'($urandom_range(1, 40)), 1'b0);
      run_dump(12'hFF0, 13'd33, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
